// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and constants for the memory-stage sequencer.
// Imported by memory_stage_sequencer and mem_lane_align.
package mem_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ1,
      S_WAIT1,
      S_REQ2,
      S_WAIT2,
      S_DONE
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] LOAD_SRC = 2'b01;

   function automatic logic is_half(
      input logic [2:0] f3
   );
      return (f3 == F3_H) || (f3 == F3_HU);
   endfunction

   function automatic logic is_byte(
      input logic [2:0] f3
   );
      return (f3 == F3_B) || (f3 == F3_BU);
   endfunction

   function automatic logic misaligned(
      input logic [2:0] f3,
      input logic [1:0] a
   );
      return (is_half(f3) && a[0]) ||
             ((f3 == F3_W) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store byte-lane placement and load extract/extend
// for one M-lane; purely combinational.
module mem_lane_align
   import mem_seq_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] sdata,
   output logic [31:0] ldata
);

   logic       sz_b;
   logic       sz_h;
   logic       sext;
   logic [7:0] rbyte;
   logic [15:0] rhalf;

   assign sz_b  = is_byte(funct3);
   assign sz_h  = is_half(funct3);
   assign sext  = (funct3 == F3_B) ||
                  (funct3 == F3_H);
   assign rbyte = rdata[{offset, 3'b000} +: 8];
   assign rhalf = rdata[{offset[1], 4'b0000} +: 16];

   // Pick byte lanes and extension from the access size
   always_comb begin
      be    = 4'hF;
      sdata = wdata;
      ldata = rdata;
      unique case (1'b1)
         sz_b: begin
            be    = 4'b0001 << offset;
            sdata = {4{wdata[7:0]}};
            ldata = {{24{sext & rbyte[7]}}, rbyte};
         end
         sz_h: begin
            be    = 4'b0011 << {offset[1], 1'b0};
            sdata = {2{wdata[15:0]}};
            ldata = {{16{sext & rhalf[15]}}, rhalf};
         end
         default: begin
            be    = 4'hF;
            sdata = wdata;
            ldata = rdata;
         end
      endcase
   end

endmodule

// File: rtl/memory_stage_sequencer.sv
// memory_stage_sequencer: serialises both M-lane memory ops onto one port.
// Optional MEM_SEQ_MISALIGN_CHECK_EN adds misalign_err and skips bad ops.
module memory_stage_sequencer
   import mem_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteM1,
   input  logic        RegWriteM2,
   input  logic [1:0]  ResultSrcM1,
   input  logic [1:0]  ResultSrcM2,
   input  logic        MemWriteM1,
   input  logic        MemWriteM2,
   input  logic [2:0]  AddressingControlM1,
   input  logic [2:0]  AddressingControlM2,
   input  logic [31:0] ALUResultM1,
   input  logic [31:0] ALUResultM2,
   input  logic [31:0] WriteDataM1,
   input  logic [31:0] WriteDataM2,
   output logic        mem_stall,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   input  logic        dm_ready,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic [31:0] ReadDataM1,
   output logic [31:0] ReadDataM2
`ifdef MEM_SEQ_MISALIGN_CHECK_EN
   ,
   output logic [1:0]  misalign_err
`endif
);

   state_t state;
   state_t state_nx;

   logic        ld1;
   logic        ld2;
   logic        mem1;
   logic        mem2;
   logic        mis1;
   logic        mis2;
   logic [1:0]  mis_pulse;
   logic [3:0]  be1;
   logic [3:0]  be2;
   logic [31:0] sd1;
   logic [31:0] sd2;
   logic [31:0] lv1;
   logic [31:0] lv2;
   logic        unused_ok;

   assign ld1  = (ResultSrcM1 == LOAD_SRC);
   assign ld2  = (ResultSrcM2 == LOAD_SRC);
   assign mem1 = ld1 | MemWriteM1;
   assign mem2 = ld2 | MemWriteM2;

`ifdef MEM_SEQ_MISALIGN_CHECK_EN
   assign mis1 = misaligned(AddressingControlM1,
                            ALUResultM1[1:0]);
   assign mis2 = misaligned(AddressingControlM2,
                            ALUResultM2[1:0]);
   assign misalign_err = mis_pulse;
   assign unused_ok = ^{RegWriteM1, RegWriteM2};
`else
   assign mis1 = 1'b0;
   assign mis2 = 1'b0;
   assign unused_ok = ^{RegWriteM1, RegWriteM2,
                        mis_pulse};
`endif

   mem_lane_align u_lane1 (
      .funct3 (AddressingControlM1),
      .offset (ALUResultM1[1:0]),
      .wdata  (WriteDataM1),
      .rdata  (dm_rdata),
      .be     (be1),
      .sdata  (sd1),
      .ldata  (lv1)
   );

   mem_lane_align u_lane2 (
      .funct3 (AddressingControlM2),
      .offset (ALUResultM2[1:0]),
      .wdata  (WriteDataM2),
      .rdata  (dm_rdata),
      .be     (be2),
      .sdata  (sd2),
      .ldata  (lv2)
   );

   // Hold the front end while any bundle memory work is outstanding
   always_comb begin
      mem_stall = 1'b0;
      if (rst_n) begin
         mem_stall = ((state == S_IDLE) && (mem1 | mem2)) ||
                     ((state != S_IDLE) && (state != S_DONE));
      end
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and memory-port drive; port is zero unless requesting
   always_comb begin
      state_nx  = state;
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_addr   = 32'h0;
      dm_wdata  = 32'h0;
      dm_be     = 4'h0;
      mis_pulse = 2'b00;
      unique case (state)
         S_IDLE: begin
            if (mem1) begin
               state_nx = S_REQ1;
            end else if (mem2) begin
               state_nx = S_REQ2;
            end
         end
         S_REQ1: begin
            if (mis1) begin
               mis_pulse[0] = 1'b1;
               state_nx = mem2 ? S_REQ2 : S_DONE;
            end else begin
               dm_req   = 1'b1;
               dm_we    = MemWriteM1;
               dm_addr  = {ALUResultM1[31:2], 2'b00};
               dm_be    = be1;
               dm_wdata = MemWriteM1 ? sd1 : 32'h0;
               if (dm_ready) begin
                  state_nx = S_WAIT1;
               end
            end
         end
         S_WAIT1: begin
            if (dm_rvalid) begin
               state_nx = mem2 ? S_REQ2 : S_DONE;
            end
         end
         S_REQ2: begin
            if (mis2) begin
               mis_pulse[1] = 1'b1;
               state_nx = S_DONE;
            end else begin
               dm_req   = 1'b1;
               dm_we    = MemWriteM2;
               dm_addr  = {ALUResultM2[31:2], 2'b00};
               dm_be    = be2;
               dm_wdata = MemWriteM2 ? sd2 : 32'h0;
               if (dm_ready) begin
                  state_nx = S_WAIT2;
               end
            end
         end
         S_WAIT2: begin
            if (dm_rvalid) begin
               state_nx = S_DONE;
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Clear results when a bundle starts, capture loads on response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ReadDataM1 <= 32'h0;
         ReadDataM2 <= 32'h0;
      end else begin
         if ((state == S_IDLE) && (mem1 | mem2)) begin
            ReadDataM1 <= 32'h0;
            ReadDataM2 <= 32'h0;
         end
         if ((state == S_WAIT1) && dm_rvalid && ld1) begin
            ReadDataM1 <= lv1;
         end
         if ((state == S_WAIT2) && dm_rvalid && ld2) begin
            ReadDataM2 <= lv2;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage_sequencer.sv
// tb_memory_stage_sequencer: directed and random bundles against a
// word-memory model with randomised ready/response timing.
module tb_memory_stage_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteM1, RegWriteM2;
   logic [1:0]  ResultSrcM1, ResultSrcM2;
   logic        MemWriteM1, MemWriteM2;
   logic [2:0]  AddressingControlM1, AddressingControlM2;
   logic [31:0] ALUResultM1, ALUResultM2;
   logic [31:0] WriteDataM1, WriteDataM2;
   logic        mem_stall, dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ready, dm_rvalid;
   logic [31:0] dm_rdata;
   logic [31:0] ReadDataM1, ReadDataM2;
   logic [1:0]  misalign_err;

`ifdef MEM_SEQ_MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
   assign misalign_err = 2'b00;
`endif

   int checks = 0;
   int errors = 0;
   int last_stalls;

   bit          ld [2];
   bit          st [2];
   logic [2:0]  f3 [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   int          rw [2];
   int          lat [2];
   logic [31:0] mem [logic [31:0]];

   always #5 clk = ~clk;

   memory_stage_sequencer dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .RegWriteM1          (RegWriteM1),
      .RegWriteM2          (RegWriteM2),
      .ResultSrcM1         (ResultSrcM1),
      .ResultSrcM2         (ResultSrcM2),
      .MemWriteM1          (MemWriteM1),
      .MemWriteM2          (MemWriteM2),
      .AddressingControlM1 (AddressingControlM1),
      .AddressingControlM2 (AddressingControlM2),
      .ALUResultM1         (ALUResultM1),
      .ALUResultM2         (ALUResultM2),
      .WriteDataM1         (WriteDataM1),
      .WriteDataM2         (WriteDataM2),
      .mem_stall           (mem_stall),
      .dm_req              (dm_req),
      .dm_we               (dm_we),
      .dm_addr             (dm_addr),
      .dm_wdata            (dm_wdata),
      .dm_be               (dm_be),
      .dm_ready            (dm_ready),
      .dm_rvalid           (dm_rvalid),
      .dm_rdata            (dm_rdata),
      .ReadDataM1          (ReadDataM1),
      .ReadDataM2          (ReadDataM2)
`ifdef MEM_SEQ_MISALIGN_CHECK_EN
      ,
      .misalign_err        (misalign_err)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   function automatic bit misal(input logic [2:0] f,
                                input logic [31:0] a);
      if (f == 3'b001 || f == 3'b101) return (a % 2) != 0;
      if (f == 3'b010) return (a % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f,
                                         input logic [31:0] a);
      if (f == 3'b000) return 4'(1 << (a % 4));
      if (f == 3'b001) return 4'(3 << (a & 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f,
                                          input logic [31:0] w);
      if (f == 3'b000) return (w & 32'hFF) * 32'h01010101;
      if (f == 3'b001) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] exp_ld(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] w);
      logic [31:0] v;
      v = w;
      if (f == 3'b000 || f == 3'b100) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (f == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end else if (f == 3'b001 || f == 3'b101) begin
         v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (f == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      return v;
   endfunction

   function automatic logic [1:0] other_src();
      logic [1:0] s;
      s = 2'($urandom_range(0, 2));
      return (s == 2'b01) ? 2'b11 : s;
   endfunction

   task automatic mem_get(input logic [31:0] wa,
                          output logic [31:0] w);
      if (!mem.exists(wa)) mem[wa] = $urandom;
      w = mem[wa];
   endtask

   task automatic set_lane(input int i, input bit l, input bit s,
                           input logic [2:0] f,
                           input logic [31:0] a,
                           input logic [31:0] w,
                           input int r, input int lt);
      ld[i] = l; st[i] = s; f3[i] = f; ad[i] = a; wd[i] = w;
      rw[i] = r; lat[i] = lt;
   endtask

   task automatic drive();
      RegWriteM1 = 1'($urandom);
      RegWriteM2 = 1'($urandom);
      ResultSrcM1 = ld[0] ? 2'b01 : other_src();
      ResultSrcM2 = ld[1] ? 2'b01 : other_src();
      MemWriteM1 = st[0];
      MemWriteM2 = st[1];
      AddressingControlM1 = f3[0];
      AddressingControlM2 = f3[1];
      ALUResultM1 = ad[0];
      ALUResultM2 = ad[1];
      WriteDataM1 = wd[0];
      WriteDataM2 = wd[1];
   endtask

   task automatic run_bundle(input string tag);
      int nops, idx, stalls, exp_stall, rcnt, pend, ln;
      int lane_of [2];
      bit mis [2];
      bit lmis [2];
      bit got_done;
      logic [31:0] exp_rd [2];
      logic [31:0] resp, w, xb;
      logic [3:0] be;
      nops = 0; exp_stall = 0;
      lmis[0] = 0; lmis[1] = 0;
      exp_rd[0] = 0; exp_rd[1] = 0;
      for (int i = 0; i < 2; i++) begin
         if (ld[i] || st[i]) begin
            lane_of[nops] = i;
            mis[nops] = CHK && misal(f3[i], ad[i]);
            lmis[i] = mis[nops];
            exp_stall += mis[nops] ? 1 : 2 + rw[i] + lat[i] - 1;
            nops++;
         end
      end
      if (nops > 0) exp_stall += 1;
      drive();
      #1;
      idx = 0; stalls = 0; pend = 0; got_done = 0; resp = 0;
      rcnt = (nops > 0) ? rw[lane_of[0]] : 0;
      for (int c = 0; c < 300 && !got_done; c++) begin
         dm_rvalid = 1'b0;
         dm_rdata = $urandom;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               dm_rvalid = 1'b1;
               dm_rdata = resp;
            end
         end
         if (mem_stall) stalls++;
         if (misalign_err != 2'b00) begin
            chk({tag, " misalign_err"}, 32'(misalign_err),
                (idx < nops && mis[idx]) ?
                32'(1 << lane_of[idx]) : 32'd0);
            chk({tag, " req_on_misalign"}, 32'(dm_req), 0);
            if (idx < nops && mis[idx]) begin
               idx++;
               rcnt = (idx < nops) ? rw[lane_of[idx]] : 0;
            end
         end
         if (dm_req) begin
            if (idx >= nops || mis[idx]) begin
               chk({tag, " unexpected_req"}, 32'(dm_req), 0);
               dm_ready = 1'b1;
            end else begin
               ln = lane_of[idx];
               chk({tag, " addr"}, dm_addr, ad[ln] & ~32'd3);
               chk({tag, " we"}, 32'(dm_we), 32'(st[ln]));
               if (st[ln]) begin
                  chk({tag, " be"}, 32'(dm_be),
                      32'(exp_be(f3[ln], ad[ln])));
                  chk({tag, " wdata"}, dm_wdata,
                      exp_wd(f3[ln], wd[ln]));
               end
               if (rcnt > 0) begin
                  dm_ready = 1'b0;
                  rcnt--;
                  if ($urandom_range(0, 3) == 0) dm_rvalid = 1'b1;
               end else begin
                  dm_ready = 1'b1;
                  mem_get(ad[ln] & ~32'd3, w);
                  if (st[ln]) begin
                     be = exp_be(f3[ln], ad[ln]);
                     xb = exp_wd(f3[ln], wd[ln]);
                     for (int k = 0; k < 4; k++)
                        if (be[k]) w[8*k +: 8] = xb[8*k +: 8];
                     mem[ad[ln] & ~32'd3] = w;
                     resp = $urandom;
                  end else begin
                     resp = w;
                     exp_rd[ln] = exp_ld(f3[ln], ad[ln], w);
                  end
                  pend = lat[ln];
                  idx++;
                  rcnt = (idx < nops) ? rw[lane_of[idx]] : 0;
               end
            end
         end else begin
            dm_ready = 1'($urandom);
            chk({tag, " idle_port"},
                dm_addr | dm_wdata | {27'd0, dm_be, dm_we}, 0);
            if (!mem_stall && (nops == 0 || stalls > 0)) begin
               got_done = 1'b1;
               if (pend == 0) dm_rvalid = 1'($urandom);
            end
         end
         if (!got_done) begin
            @(negedge clk);
            #1;
         end
      end
      last_stalls = stalls;
      if (!got_done) begin
         chk({tag, " timeout"}, 0, 1);
      end else begin
         chk({tag, " stall_cycles"}, stalls, exp_stall);
         chk({tag, " ops_done"}, idx, nops);
         if (ld[0] || lmis[0])
            chk({tag, " ReadDataM1"}, ReadDataM1, exp_rd[0]);
         if (ld[1] || lmis[1])
            chk({tag, " ReadDataM2"}, ReadDataM2, exp_rd[1]);
      end
   endtask

   task automatic rand_lane(input int i);
      int k;
      logic [2:0] fl [5];
      fl[0] = 3'b000; fl[1] = 3'b001; fl[2] = 3'b010;
      fl[3] = 3'b100; fl[4] = 3'b101;
      k = $urandom_range(0, 2);
      set_lane(i, k == 1, k == 2,
               (k == 1) ? fl[$urandom_range(0, 4)] :
               (k == 2) ? fl[$urandom_range(0, 2)] :
               3'($urandom),
               32'h100 + $urandom_range(0, 31), $urandom,
               $urandom_range(0, 2), $urandom_range(1, 3));
   endtask

   initial begin
      rst_n = 1'b0;
      dm_ready = 1'b0;
      dm_rvalid = 1'b0;
      dm_rdata = 32'h0;
      set_lane(0, 1, 0, 3'b010, 32'h100, 0, 0, 1);
      set_lane(1, 0, 1, 3'b010, 32'h104, 1, 0, 1);
      drive();
      @(negedge clk);
      #1;
      chk("rst mem_stall", 32'(mem_stall), 0);
      chk("rst dm_req", 32'(dm_req), 0);
      chk("rst port", dm_addr | dm_wdata | {27'd0, dm_be, dm_we}, 0);
      chk("rst ReadDataM1", ReadDataM1, 0);
      chk("rst ReadDataM2", ReadDataM2, 0);
      chk("rst misalign_err", 32'(misalign_err), 0);
      set_lane(0, 0, 0, 0, 0, 0, 0, 1);
      set_lane(1, 0, 0, 0, 0, 0, 0, 1);
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_bundle("nop");
      chk("nop stall", last_stalls, 0);

      @(negedge clk);
      set_lane(0, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1);
      run_bundle("sw");
      chk("sw stall", last_stalls, 3);

      @(negedge clk);
      set_lane(0, 0, 1, 3'b000, 32'h103, 32'h12345678, 0, 1);
      set_lane(1, 1, 0, 3'b000, 32'h103, 0, 0, 1);
      run_bundle("sb_lb");
      chk("sb_lb stall", last_stalls, 5);
      chk("sb_lb ReadDataM2", ReadDataM2, 32'h00000078);

      @(negedge clk);
      mem[32'h100] = 32'h80010000;
      set_lane(0, 1, 0, 3'b001, 32'h102, 0, 0, 1);
      set_lane(1, 0, 0, 0, 0, 0, 0, 1);
      run_bundle("lh");
      chk("lh value", ReadDataM1, 32'hFFFF8001);
      @(negedge clk);
      set_lane(0, 1, 0, 3'b101, 32'h102, 0, 0, 1);
      run_bundle("lhu");
      chk("lhu value", ReadDataM1, 32'h00008001);

      @(negedge clk);
      set_lane(0, 1, 0, 3'b101, 32'h102, 0, 2, 3);
      run_bundle("slow");
      chk("slow stall", last_stalls, 7);
      chk("slow value", ReadDataM1, 32'h00008001);

      @(negedge clk);
      set_lane(0, 1, 0, 3'b010, 32'h104, 0, 0, 1);
      drive();
      dm_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rstmid req1", 32'(dm_req), 1);
      @(negedge clk);
      #1;
      chk("rstmid wait1 stall", 32'(mem_stall), 1);
      chk("rstmid wait1 req", 32'(dm_req), 0);
      rst_n = 1'b0;
      #1;
      chk("rstmid stall", 32'(mem_stall), 0);
      chk("rstmid port", dm_addr | dm_wdata | {27'd0, dm_be, dm_we}, 0);
      chk("rstmid ReadDataM1", ReadDataM1, 0);
      set_lane(0, 0, 0, 0, 0, 0, 0, 1);
      drive();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dm_rvalid = 1'b1;
      dm_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      #1;
      dm_rvalid = 1'b0;
      chk("stale ReadDataM1", ReadDataM1, 0);
      chk("stale stall", 32'(mem_stall), 0);
      chk("stale req", 32'(dm_req), 0);
      @(negedge clk);
      set_lane(0, 1, 0, 3'b010, 32'h104, 0, 0, 1);
      run_bundle("after_rst");
      chk("after_rst stall", last_stalls, 3);

      @(negedge clk);
      set_lane(0, 1, 0, 3'b010, 32'h101, 0, 0, 1);
      run_bundle("lw_misalign");
      chk("lw_misalign stall", last_stalls, CHK ? 2 : 3);

      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         rand_lane(0);
         rand_lane(1);
         run_bundle("rand");
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
